// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    // Responder FSM states; the encoding is fixed so that waveforms read consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Maps a little-endian byte lane onto a one-hot byte enable.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0001 << lane;
        return mask;
    endfunction

    // Sign-extends a loaded byte to a full word.
    function automatic logic [31:0] sext_byte(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and the data memory.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: merges store bytes into the old word and extracts load bytes.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [7:0]  wbyte,
    input  logic [1:0]  lane,
    output logic [31:0] merged_word,
    output logic [31:0] lb_data
);

    // Replace only the addressed lane for sb, and sign-extend the addressed lane for lb.
    always_comb begin
        logic [3:0] be;
        be          = lane_mask(lane);
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged_word[8*i +: 8] = wbyte;
            end
        end
        lb_data = sext_byte(old_word[8*lane +: 8]);
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port: one request at a time,
// fixed wait states, word-addressed store with lw/sw/lb/sb and error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam int         AW       = ADDR_WIDTH + 2;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic            byte_q, byte_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;

    logic [31:0]     mem_q [DEPTH];
    logic            mem_we;
    logic [31:0]     mem_wdata;

    logic            use_req;
    logic            op_write;
    logic            op_byte;
    logic [AW-1:0]   op_addr;
    logic [31:0]     op_wdata;
    logic            req_err;
    logic [31:0]     old_word;
    logic [31:0]     merged_word;
    logic [31:0]     lb_data;

    // In IDLE a zero-wait access is performed straight from the bus; otherwise from the latched request.
    always_comb begin
        use_req  = (state_q == ST_IDLE);
        op_write = use_req ? bus.req_write : write_q;
        op_byte  = use_req ? bus.req_byte  : byte_q;
        op_addr  = use_req ? bus.req_addr[AW-1:0] : addr_q;
        op_wdata = use_req ? bus.req_wdata : wdata_q;
        req_err  = (!bus.req_byte && (bus.req_addr[1:0] != 2'b00))
                 || (bus.req_addr[31:AW] != '0);
        old_word = mem_q[op_addr[AW-1:2]];
    end

    dmem_lane_align u_align (
        .old_word    (old_word),
        .wbyte       (op_wdata[7:0]),
        .lane        (op_addr[1:0]),
        .merged_word (merged_word),
        .lb_data     (lb_data)
    );

    // Next-state, wait counter, request latch, store write strobe and response data.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_we      = 1'b0;
        mem_wdata   = op_byte ? merged_word : op_wdata;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    byte_d  = bus.req_byte;
                    addr_d  = bus.req_addr[AW-1:0];
                    wdata_d = bus.req_wdata;
                    if (req_err) begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_error_d = 1'b1;
                    end else if (NO_WAIT) begin
                        state_d     = ST_RESP;
                        mem_we      = op_write;
                        rsp_rdata_d = op_write ? 32'd0 : (op_byte ? lb_data : old_word);
                        rsp_error_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    mem_we      = op_write;
                    rsp_rdata_d = op_write ? 32'd0 : (op_byte ? lb_data : old_word);
                    rsp_error_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = 32'd0;
                    rsp_error_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any in-flight request or response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Data store; contents survive reset, but a write coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[op_addr[AW-1:2]] <= mem_wdata;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with WAIT_CYCLES of 1, 3 and 0.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          sel = 0;
    logic        tb_valid = 1'b0;
    logic        tb_write = 1'b0;
    logic        tb_byte = 1'b0;
    logic [31:0] tb_addr = 32'd0;
    logic [31:0] tb_wdata = 32'd0;
    logic        tb_rsp_ready = 1'b0;

    int total = 0;
    int bad = 0;

    bit [31:0] model_mem [3][1024];
    bit        known     [3][1024];

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();
    dmem_responder_if if_c ();

    // Shared request fields; only the selected instance sees valid/ready.
    assign if_a.req_valid = tb_valid && (sel == 0);
    assign if_b.req_valid = tb_valid && (sel == 1);
    assign if_c.req_valid = tb_valid && (sel == 2);
    assign if_a.rsp_ready = tb_rsp_ready && (sel == 0);
    assign if_b.rsp_ready = tb_rsp_ready && (sel == 1);
    assign if_c.rsp_ready = tb_rsp_ready && (sel == 2);
    assign if_a.req_write = tb_write;
    assign if_b.req_write = tb_write;
    assign if_c.req_write = tb_write;
    assign if_a.req_byte  = tb_byte;
    assign if_b.req_byte  = tb_byte;
    assign if_c.req_byte  = tb_byte;
    assign if_a.req_addr  = tb_addr;
    assign if_b.req_addr  = tb_addr;
    assign if_c.req_addr  = tb_addr;
    assign if_a.req_wdata = tb_wdata;
    assign if_b.req_wdata = tb_wdata;
    assign if_c.req_wdata = tb_wdata;

    logic        cur_req_ready;
    logic        cur_rsp_valid;
    logic [31:0] cur_rsp_rdata;
    logic        cur_rsp_error;

    assign cur_req_ready = (sel == 1) ? if_b.req_ready : (sel == 2) ? if_c.req_ready : if_a.req_ready;
    assign cur_rsp_valid = (sel == 1) ? if_b.rsp_valid : (sel == 2) ? if_c.rsp_valid : if_a.rsp_valid;
    assign cur_rsp_rdata = (sel == 1) ? if_b.rsp_rdata : (sel == 2) ? if_c.rsp_rdata : if_a.rsp_rdata;
    assign cur_rsp_error = (sel == 1) ? if_b.rsp_error : (sel == 2) ? if_c.rsp_error : if_a.rsp_error;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 1) ? 3 : (s == 2) ? 0 : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request to the selected instance, checks latency and response against the model,
    // optionally stalls the response for 'hold' cycles, then takes it and checks the return to idle.
    task automatic apply_stimulus(input bit wr, input bit bt, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int hold);
        int          n;
        int          idx;
        int          lane;
        bit          exp_err;
        bit          rd_known;
        logic [31:0] exp_rd;
        logic [31:0] b;
        logic [31:0] held;

        idx      = int'((addr / 4) % 1024);
        lane     = int'(addr % 4);
        exp_err  = ((!bt) && (addr % 4 != 0)) || (addr >= 32'd4096);
        rd_known = 1'b1;
        exp_rd   = 32'd0;
        if (!exp_err && !wr) begin
            rd_known = known[sel][idx];
            if (bt) begin
                b      = (model_mem[sel][idx] >> (8 * lane)) & 32'hFF;
                exp_rd = (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            end else begin
                exp_rd = model_mem[sel][idx];
            end
        end
        if (!exp_err && wr) begin
            if (bt) begin
                model_mem[sel][idx] = (model_mem[sel][idx] & ~(32'hFF << (8 * lane)))
                                    | ((wdata & 32'hFF) << (8 * lane));
            end else begin
                model_mem[sel][idx] = wdata;
                known[sel][idx]     = 1'b1;
            end
        end

        n = 0;
        while (!cur_req_ready && n < 50) begin
            step();
            n++;
        end
        check_output("req_ready_before", 32'(cur_req_ready), 32'd1);

        tb_write = wr;
        tb_byte  = bt;
        tb_addr  = addr;
        tb_wdata = wdata;
        tb_valid = 1'b1;
        step();
        tb_valid = 1'b0;
        tb_addr  = $urandom;
        tb_wdata = $urandom;
        n = 1;
        while (!cur_rsp_valid && n < 50) begin
            step();
            n++;
        end
        check_output("latency", 32'(n), exp_err ? 32'd1 : 32'(wait_of(sel) + 1));
        check_output("rsp_error", 32'(cur_rsp_error), 32'(exp_err));
        if (rd_known) begin
            check_output("rsp_rdata", cur_rsp_rdata, exp_rd);
        end
        check_output("req_ready_busy", 32'(cur_req_ready), 32'd0);

        held = cur_rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            step();
            check_output("hold_valid", 32'(cur_rsp_valid), 32'd1);
            check_output("hold_rdata", cur_rsp_rdata, held);
            check_output("hold_req_ready", 32'(cur_req_ready), 32'd0);
        end

        tb_rsp_ready = 1'b1;
        step();
        tb_rsp_ready = 1'b0;
        check_output("idle_valid", 32'(cur_rsp_valid), 32'd0);
        check_output("idle_rdata", cur_rsp_rdata, 32'd0);
        check_output("idle_error", 32'(cur_rsp_error), 32'd0);
        check_output("idle_req_ready", 32'(cur_req_ready), 32'd1);
    endtask

    initial begin
        int          n;
        bit          wr;
        bit          bt;
        logic [31:0] addr;

        reset = 1'b1;
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check_output("reset_req_ready", 32'(cur_req_ready), 32'd1);
            check_output("reset_rsp_valid", 32'(cur_rsp_valid), 32'd0);
            check_output("reset_rsp_rdata", cur_rsp_rdata, 32'd0);
            check_output("reset_rsp_error", 32'(cur_rsp_error), 32'd0);
        end
        reset = 1'b0;
        sel = 0;
        step();

        $display("[TB] directed word/byte/error sequence");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 0);
        apply_stimulus(1'b1, 1'b1, 32'h11, 32'h80, 0);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 0);
        apply_stimulus(1'b0, 1'b1, 32'h11, 32'h0, 0);
        apply_stimulus(1'b0, 1'b1, 32'h13, 32'h0, 0);
        apply_stimulus(1'b0, 1'b0, 32'h12, 32'h0, 0);
        apply_stimulus(1'b1, 1'b0, 32'h1000, 32'h1, 0);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 5);

        $display("[TB] reset during WAIT on the 3-wait instance");
        sel = 1;
        #0;
        apply_stimulus(1'b1, 1'b0, 32'h20, 32'h11111111, 0);
        tb_write = 1'b1;
        tb_byte  = 1'b0;
        tb_addr  = 32'h20;
        tb_wdata = 32'h55;
        tb_valid = 1'b1;
        step();
        tb_valid = 1'b0;
        step();
        check_output("wait_no_rsp", 32'(cur_rsp_valid), 32'd0);
        check_output("wait_busy", 32'(cur_req_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("abort_req_ready", 32'(cur_req_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cur_rsp_valid) n++;
        end
        check_output("abort_no_rsp", 32'(n), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h20, 32'h0, 0);

        $display("[TB] randomized traffic");
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            for (int w = 0; w < 16; w++) begin
                apply_stimulus(1'b1, 1'b0, 32'(w * 4), $urandom, 0);
            end
            for (int k = 0; k < 40; k++) begin
                wr   = 1'($urandom_range(0, 1));
                bt   = 1'($urandom_range(0, 1));
                addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) begin
                    addr = addr | (32'h1 << $urandom_range(12, 31));
                end
                apply_stimulus(wr, bt, addr, $urandom, $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
